// File: rtl/pcseq_pkg.sv
// Shared definitions for the PC phase sequencer: FSM state encoding and
// the legal range of the PHASES parameter.
package pcseq_pkg;

    typedef enum logic [1:0] {
        PCSEQ_IDLE = 2'd0,
        PCSEQ_RUN  = 2'd1,
        PCSEQ_HOLD = 2'd2
    } pcseq_state_e;

    localparam int unsigned PCSEQ_PHASES_MIN = 2;
    localparam int unsigned PCSEQ_PHASES_MAX = 16;

    // True when a PHASES value is inside the supported range.
    function automatic bit pcseq_phases_legal(input int unsigned phases);
        return (phases >= PCSEQ_PHASES_MIN) && (phases <= PCSEQ_PHASES_MAX);
    endfunction

endpackage

// File: rtl/pcseq_phase_cnt.sv
// Modulo-PHASES phase counter with clear, hold and explicit wrap, plus a
// gated one-hot decode of the current phase.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        force phase to 0 on the next edge (wins over i_adv)
//   i_adv        advance phase by one, wrapping PHASES-1 -> 0
//   i_oh_en      enable the one-hot decode (all-zero when low)
//   o_phase      current phase index
//   o_phase_oh   one-hot decode of o_phase
//   o_last_c     combinational: phase is PHASES-1
module pcseq_phase_cnt #(
    parameter int unsigned PHASES  = 2,
    parameter int unsigned PHASE_W = $clog2(PHASES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clr,
    input  logic               i_adv,
    input  logic               i_oh_en,
    output logic [PHASE_W-1:0] o_phase,
    output logic [PHASES-1:0]  o_phase_oh,
    output logic               o_last_c
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

    logic [PHASE_W-1:0] r_phase;

    // Explicit compare so non-power-of-2 PHASES wraps correctly.
    assign o_last_c = (r_phase == LAST_PHASE);
    assign o_phase  = r_phase;

    // Phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (i_clr) begin
            r_phase <= '0;
        end else if (i_adv) begin
            r_phase <= o_last_c ? '0 : r_phase + PHASE_W'(1);
        end
    end

    // One-hot decode, bounded to PHASES bits.
    always_comb begin
        o_phase_oh = '0;
        for (int unsigned i = 0; i < PHASES; i++) begin
            o_phase_oh[i] = i_oh_en && (r_phase == PHASE_W'(i));
        end
    end

endmodule

// File: rtl/pc_phase_sequencer.sv
// PC phase sequencer: walks each instruction through PHASES cycles and
// emits a one-cycle PC set-enable on the last phase, with stall, flush
// and run/stop control.
// Optional feature: define PCSEQ_RETIRE_CNT_EN to add the 32-bit retired
// instruction counter output PCSEQ_Retired.
// Ports:
//   PCSEQ_Clk       system clock
//   PCSEQ_Reset     asynchronous active-low reset
//   PCSEQ_En        run request; low stops sequencing
//   PCSEQ_Stall     hold current phase
//   PCSEQ_Flush     abort instruction, restart at phase 0
//   PCSEQ_Set_En    PC load enable (combinational), one per instruction
//   PCSEQ_Phase     current phase index
//   PCSEQ_Phase_Oh  one-hot phase, zero in IDLE
//   PCSEQ_Busy      high in RUN or HOLD
//   PCSEQ_Retired   (optional) count of Set_En pulses
module pc_phase_sequencer
    import pcseq_pkg::*;
#(
    parameter int unsigned PHASES  = 2,
    parameter int unsigned PHASE_W = $clog2(PHASES)
) (
    input  logic               PCSEQ_Clk,
    input  logic               PCSEQ_Reset,
    input  logic               PCSEQ_En,
    input  logic               PCSEQ_Stall,
    input  logic               PCSEQ_Flush,
    output logic               PCSEQ_Set_En,
    output logic [PHASE_W-1:0] PCSEQ_Phase,
    output logic [PHASES-1:0]  PCSEQ_Phase_Oh,
    output logic               PCSEQ_Busy
`ifdef PCSEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]        PCSEQ_Retired
`endif
);

    generate
        if (!pcseq_phases_legal(PHASES)) begin : g_bad_phases
            $error("pc_phase_sequencer: PHASES must be within 2..16");
        end
    endgenerate

    pcseq_state_e r_state;
    pcseq_state_e w_state_nxt;
    logic         w_clr;
    logic         w_adv;
    logic         w_last;

    // State register.
    always_ff @(posedge PCSEQ_Clk or negedge PCSEQ_Reset) begin
        if (!PCSEQ_Reset) begin
            r_state <= PCSEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and counter control; priority Flush > ~En > Stall > advance.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            PCSEQ_IDLE: begin
                w_clr = 1'b1;
                if (PCSEQ_En) begin
                    w_state_nxt = PCSEQ_RUN;
                end
            end
            PCSEQ_RUN, PCSEQ_HOLD: begin
                if (PCSEQ_Flush) begin
                    w_clr       = 1'b1;
                    w_state_nxt = PCSEQ_En ? PCSEQ_RUN : PCSEQ_IDLE;
                end else if (!PCSEQ_En) begin
                    w_clr       = 1'b1;
                    w_state_nxt = PCSEQ_IDLE;
                end else if (PCSEQ_Stall) begin
                    w_state_nxt = PCSEQ_HOLD;
                end else begin
                    // Leaving HOLD re-executes the held phase before advancing.
                    w_state_nxt = PCSEQ_RUN;
                    w_adv       = (r_state == PCSEQ_RUN);
                end
            end
            default: begin
                w_clr       = 1'b1;
                w_state_nxt = PCSEQ_IDLE;
            end
        endcase
    end

    assign PCSEQ_Busy = (r_state != PCSEQ_IDLE);

    pcseq_phase_cnt #(
        .PHASES  (PHASES),
        .PHASE_W (PHASE_W)
    ) u_phase_cnt (
        .clk        (PCSEQ_Clk),
        .rst_n      (PCSEQ_Reset),
        .i_clr      (w_clr),
        .i_adv      (w_adv),
        .i_oh_en    (PCSEQ_Busy),
        .o_phase    (PCSEQ_Phase),
        .o_phase_oh (PCSEQ_Phase_Oh),
        .o_last_c   (w_last)
    );

    // Fires only on a cycle that actually completes the last phase.
    assign PCSEQ_Set_En = (r_state == PCSEQ_RUN) && w_last && PCSEQ_En
                          && !PCSEQ_Stall && !PCSEQ_Flush;

`ifdef PCSEQ_RETIRE_CNT_EN
    logic [31:0] r_retired;

    // Retired instruction counter; only reset clears it.
    always_ff @(posedge PCSEQ_Clk or negedge PCSEQ_Reset) begin
        if (!PCSEQ_Reset) begin
            r_retired <= '0;
        end else if (PCSEQ_Set_En) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign PCSEQ_Retired = r_retired;
`endif

endmodule

// File: tb/tb_pc_phase_sequencer.sv
// Bench for pc_phase_sequencer: three instances (PHASES = 2, 3, 4) share
// one stimulus stream; a behavioural model predicts every cycle's outputs
// into per-instance queues which a monitor drains and compares.
module tb_pc_phase_sequencer;

    localparam int NI = 3;   // instance i has PHASES = i + 2

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, stall, flush;
    logic [NI-1:0] set_en, busy;
    logic [0:0] ph2;
    logic [1:0] ph3, ph4;
    logic [1:0] oh2;
    logic [2:0] oh3;
    logic [3:0] oh4;
    logic [31:0] ret [NI];

    pc_phase_sequencer #(.PHASES(2)) u_dut2 (
        .PCSEQ_Clk(clk), .PCSEQ_Reset(rst_n), .PCSEQ_En(en),
        .PCSEQ_Stall(stall), .PCSEQ_Flush(flush), .PCSEQ_Set_En(set_en[0]),
        .PCSEQ_Phase(ph2), .PCSEQ_Phase_Oh(oh2), .PCSEQ_Busy(busy[0])
`ifdef PCSEQ_RETIRE_CNT_EN
        , .PCSEQ_Retired(ret[0])
`endif
    );
    pc_phase_sequencer #(.PHASES(3)) u_dut3 (
        .PCSEQ_Clk(clk), .PCSEQ_Reset(rst_n), .PCSEQ_En(en),
        .PCSEQ_Stall(stall), .PCSEQ_Flush(flush), .PCSEQ_Set_En(set_en[1]),
        .PCSEQ_Phase(ph3), .PCSEQ_Phase_Oh(oh3), .PCSEQ_Busy(busy[1])
`ifdef PCSEQ_RETIRE_CNT_EN
        , .PCSEQ_Retired(ret[1])
`endif
    );
    pc_phase_sequencer #(.PHASES(4)) u_dut4 (
        .PCSEQ_Clk(clk), .PCSEQ_Reset(rst_n), .PCSEQ_En(en),
        .PCSEQ_Stall(stall), .PCSEQ_Flush(flush), .PCSEQ_Set_En(set_en[2]),
        .PCSEQ_Phase(ph4), .PCSEQ_Phase_Oh(oh4), .PCSEQ_Busy(busy[2])
`ifdef PCSEQ_RETIRE_CNT_EN
        , .PCSEQ_Retired(ret[2])
`endif
    );

`ifndef PCSEQ_RETIRE_CNT_EN
    always_comb for (int i = 0; i < NI; i++) ret[i] = '0;
`endif

    logic [3:0]  act_ph [NI];
    logic [15:0] act_oh [NI];
    always_comb begin
        act_ph[0] = 4'(ph2);  act_ph[1] = 4'(ph3);  act_ph[2] = 4'(ph4);
        act_oh[0] = 16'(oh2); act_oh[1] = 16'(oh3); act_oh[2] = 16'(oh4);
    end

    typedef struct {
        logic        set_en;
        logic        busy;
        logic [3:0]  phase;
        logic [15:0] oh;
        logic [31:0] ret;
    } exp_t;

    exp_t q [NI][$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: running flag, held flag, phase as an integer.
    bit          m_busy  [NI];
    bit          m_hold  [NI];
    int          m_phase [NI];
    logic [31:0] m_ret   [NI];

    task automatic check(input string name, input int i,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s phases=%0d t=%0t got=%0h expected=%0h",
                     name, i + 2, $time, act, exp);
        end
    endtask

    function automatic void model_reset(input int i);
        m_busy[i] = 1'b0; m_hold[i] = 1'b0; m_phase[i] = 0; m_ret[i] = '0;
    endfunction

    function automatic exp_t model_out(input int i);
        exp_t e;
        e.busy   = m_busy[i];
        e.phase  = m_busy[i] ? 4'(m_phase[i]) : 4'd0;
        e.oh     = m_busy[i] ? (16'd1 << m_phase[i]) : 16'd0;
        e.set_en = m_busy[i] && !m_hold[i] && en && !stall && !flush
                   && (m_phase[i] == i + 1);
        e.ret    = m_ret[i];
        return e;
    endfunction

    // One cycle: drive inputs, predict outputs, then advance the model.
    task automatic step(input logic e_in, input logic s_in, input logic f_in);
        exp_t ex [NI];
        bit   nb [NI];
        bit   nh [NI];
        int   np [NI];
        en = e_in; stall = s_in; flush = f_in;
        for (int i = 0; i < NI; i++) begin
            ex[i] = model_out(i);
            q[i].push_back(ex[i]);
            nb[i] = m_busy[i]; nh[i] = m_hold[i]; np[i] = m_phase[i];
            if (!m_busy[i]) begin
                if (en) begin nb[i] = 1'b1; nh[i] = 1'b0; np[i] = 0; end
            end else if (flush) begin
                np[i] = 0; nh[i] = 1'b0; nb[i] = en;
            end else if (!en) begin
                nb[i] = 1'b0; nh[i] = 1'b0; np[i] = 0;
            end else if (stall) begin
                nh[i] = 1'b1;
            end else if (m_hold[i]) begin
                nh[i] = 1'b0;
            end else begin
                np[i] = (m_phase[i] + 1) % (i + 2);
            end
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                model_reset(i);
            end else begin
                m_busy[i] = nb[i]; m_hold[i] = nh[i]; m_phase[i] = np[i];
                if (ex[i].set_en) m_ret[i] = m_ret[i] + 32'd1;
            end
        end
        #1;
    endtask

    // Advance freely until instance i sits in RUN at phase ph.
    task automatic run_until(input int i, input int ph);
        int k;
        k = 0;
        while (k < 20 && !(m_busy[i] && !m_hold[i] && m_phase[i] == ph)) begin
            step(1'b1, 1'b0, 1'b0);
            k++;
        end
        check("run_until_reached", i, 32'(k < 20), 32'd1);
    endtask

    // Monitor: compare every presented cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (q[i].size() > 0) begin
                    e = q[i].pop_front();
                    check("set_en",   i, 32'(set_en[i]), 32'(e.set_en));
                    check("busy",     i, 32'(busy[i]),   32'(e.busy));
                    check("phase",    i, 32'(act_ph[i]), 32'(e.phase));
                    check("phase_oh", i, 32'(act_oh[i]), 32'(e.oh));
`ifdef PCSEQ_RETIRE_CNT_EN
                    check("retired",  i, ret[i],         e.ret);
`endif
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < NI; i++) model_reset(i);
        @(posedge clk); #1;

        // Reset held with En asserted: everything must stay at reset values.
        repeat (3) step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Free run.
        repeat (10) step(1'b1, 1'b0, 1'b0);

        // Stall three cycles on the last phase of the 4-phase instance.
        run_until(2, 3);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // Flush at phase 2.
        run_until(2, 2);
        step(1'b1, 1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b0, 1'b0);

        // Drop En at phase 2 of the 3-phase instance, then restart.
        run_until(1, 2);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0);

        // Stall and Flush together, then En falling while held.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges at phase 3.
        run_until(2, 3);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check("async_rst_set_en", i, 32'(set_en[i]), 32'd0);
            check("async_rst_busy",   i, 32'(busy[i]),   32'd0);
            check("async_rst_phase",  i, 32'(act_ph[i]), 32'd0);
            check("async_rst_oh",     i, 32'(act_oh[i]), 32'd0);
            model_reset(i);
        end
        @(posedge clk); #1;
        repeat (2) step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (8) step(1'b1, 1'b0, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 19) == 0));
        end

`ifdef PCSEQ_RETIRE_CNT_EN
        // Counter wrap from all-ones.
        force u_dut2.r_retired = 32'hFFFF_FFFF;
        #1;
        release u_dut2.r_retired;
        m_ret[0] = 32'hFFFF_FFFF;
        repeat (6) step(1'b1, 1'b0, 1'b0);
`endif

        @(negedge clk); #1;
        for (int i = 0; i < NI; i++) check("queue_drained", i, 32'(q[i].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
